// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one UART TX engine among NREQ sources.
// Define UART_ARB_TAG_EN to prefix each packet with an 8'hF0|grant tag byte.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 3170,
  parameter int CNT_W   = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic [IDX_W-1:0]  grant_idx,
  output logic              timeout_pulse
);

`ifdef UART_ARB_TAG_EN
  typedef enum logic [1:0] {IDLE, TAG, XFER} state_e;
`else
  typedef enum logic [1:0] {IDLE, XFER} state_e;
`endif

  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tp_q, tp_d;

  logic             sel_valid;
  logic             sel_last;
  logic [7:0]       sel_data;
  logic [IDX_W-1:0] win;
  logic             any_req;

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  // Lowest requester above last_q wins; otherwise wrap to the lowest overall.
  always_comb begin
    win     = '0;
    any_req = |req_valid;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_valid[j]) win = IDX_W'(j);
    end
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (req_valid[j] && (IDX_W'(j) > last_q)) win = IDX_W'(j);
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    tp_d      = 1'b0;
    tx_valid  = 1'b0;
    tx_data   = '0;
    req_ready = '0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (any_req) begin
          grant_d = win;
`ifdef UART_ARB_TAG_EN
          state_d = TAG;
`else
          state_d = XFER;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      TAG: begin
        tx_valid = 1'b1;
        tx_data  = 8'hF0 | 8'(grant_q);
        if (tx_ready) begin
          state_d = XFER;
          cnt_d   = '0;
        end
      end
`endif
      XFER: begin
        tx_valid = sel_valid;
        tx_data  = sel_data;
        for (int i = 0; i < NREQ; i++) begin
          req_ready[i] = tx_ready && (grant_q == IDX_W'(i));
        end
        if (sel_valid && tx_ready) begin
          cnt_d = '0;
          if (sel_last) begin
            state_d = IDLE;
            last_d  = grant_q;
          end
        end else if (!sel_valid) begin
          // A serializer stall with valid held is not a timeout.
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          if (TO_EN && cnt_q == TO_LAST) begin
            state_d = IDLE;
            last_d  = grant_q;
            tp_d    = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      cnt_q   <= '0;
      tp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      tp_q    <= tp_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign grant_idx     = grant_q;
  assign timeout_pulse = tp_q;

endmodule
